// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPE-CPU control path: opcodes, imm_gen type codes,
// sequencer states, next-PC and writeback source codes.
package cpu_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_J    = 3'd1;
  localparam logic [2:0] IMM_U    = 3'd2;
  localparam logic [2:0] IMM_S    = 3'd3;
  localparam logic [2:0] IMM_B    = 3'd4;
  localparam logic [2:0] IMM_I    = 3'd5;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_ALU   = 2'b01;
  localparam logic [1:0] PC_BR    = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM      = 3'd4,
    ST_WB       = 3'd5
`ifdef CPU_ILLEGAL_TRAP_EN
    , ST_TRAP   = 3'd6
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_JUMP, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_ILL
  } cls_e;

  typedef struct packed {
    logic [2:0] imm_type;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] wb_sel;
    cls_e       cls;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/cpu_ctrl_fsm_decode.sv
// Combinational opcode decoder: imm type, operand selects, writeback source,
// instruction class and illegal flag.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o.imm_type  = IMM_NONE;
    dec_o.alu_a_sel = 1'b0;
    dec_o.alu_b_sel = 1'b1;
    dec_o.wb_sel    = WB_ALU;
    dec_o.cls       = CLS_ALU;
    dec_o.illegal   = 1'b0;
    // Every legal opcode ends in 2'b11, so the low-bit check falls out of the match.
    case (opcode_i)
      OPC_LUI:    dec_o.imm_type = IMM_U;
      OPC_AUIPC: begin
        dec_o.imm_type  = IMM_U;
        dec_o.alu_a_sel = 1'b1;
      end
      OPC_JAL: begin
        dec_o.imm_type  = IMM_J;
        dec_o.alu_a_sel = 1'b1;
        dec_o.wb_sel    = WB_PC4;
        dec_o.cls       = CLS_JUMP;
      end
      OPC_JALR: begin
        dec_o.imm_type = IMM_I;
        dec_o.wb_sel   = WB_PC4;
        dec_o.cls      = CLS_JUMP;
      end
      OPC_BRANCH: begin
        dec_o.imm_type  = IMM_B;
        dec_o.alu_b_sel = 1'b0;
        dec_o.cls       = CLS_BRANCH;
      end
      OPC_LOAD: begin
        dec_o.imm_type = IMM_I;
        dec_o.wb_sel   = WB_MEM;
        dec_o.cls      = CLS_LOAD;
      end
      OPC_STORE: begin
        dec_o.imm_type = IMM_S;
        dec_o.cls      = CLS_STORE;
      end
      OPC_OP_IMM: dec_o.imm_type = IMM_I;
      OPC_OP:     dec_o.alu_b_sel = 1'b0;
      default: begin
        dec_o.alu_b_sel = 1'b0;
        dec_o.cls       = CLS_ILL;
        dec_o.illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the CPE-CPU core.
// CPU_ILLEGAL_TRAP_EN: illegal opcodes lock the core in TRAP instead of running as NOP.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int RESET_DELAY = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] instr_w_i,
  input  logic        branch_taken_w_i,
  input  logic        mem_ack_w_i,
  output logic        mem_req_w_o,
  output logic        mem_we_w_o,
  output logic        mem_sel_w_o,
  output logic        ir_we_w_o,
  output logic        pc_we_w_o,
  output logic [1:0]  pc_sel_w_o,
  output logic [2:0]  imm_type_w_o,
  output logic        alu_a_sel_w_o,
  output logic        alu_b_sel_w_o,
  output logic        rf_we_w_o,
  output logic [1:0]  wb_sel_w_o,
`ifdef CPU_ILLEGAL_TRAP_EN
  output logic        illegal_w_o,
`endif
  output logic [2:0]  state_w_o
);

  localparam int CW = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_DELAY - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_req_q, mem_sel_q, mem_we_q;
  logic [2:0]    imm_type_q;
  logic          alu_a_q, alu_b_q;
  logic [1:0]    wb_sel_q;
  cls_e          cls_q;
  dec_t          dec;
  logic          unused_instr;
`ifdef CPU_ILLEGAL_TRAP_EN
  logic          ill_q;
`endif

  ctrl_decode u_dec (
    .opcode_i (instr_w_i[6:0]),
    .dec_o    (dec)
  );

  assign unused_instr = ^instr_w_i[31:12];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RST_WAIT;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      imm_type_q <= IMM_NONE;
      alu_a_q    <= 1'b0;
      alu_b_q    <= 1'b0;
      wb_sel_q   <= WB_ALU;
      cls_q      <= CLS_ALU;
`ifdef CPU_ILLEGAL_TRAP_EN
      ill_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_RST_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q   <= ST_FETCH;
            mem_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_ack_w_i) begin
            state_q   <= ST_DECODE;
            mem_req_q <= 1'b0;
          end
        end
        ST_DECODE: begin
          imm_type_q <= dec.imm_type;
          alu_a_q    <= dec.alu_a_sel;
          alu_b_q    <= dec.alu_b_sel;
          wb_sel_q   <= dec.wb_sel;
          cls_q      <= dec.cls;
          if (dec.illegal) begin
`ifdef CPU_ILLEGAL_TRAP_EN
            state_q <= ST_TRAP;
            ill_q   <= 1'b1;
`else
            state_q <= ST_WB;
`endif
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BRANCH: begin
              state_q   <= ST_FETCH;
              mem_req_q <= 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              state_q   <= ST_MEM;
              mem_req_q <= 1'b1;
              mem_sel_q <= 1'b1;
              mem_we_q  <= (cls_q == CLS_STORE);
            end
            default: state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ack_w_i) begin
            mem_sel_q <= 1'b0;
            mem_we_q  <= 1'b0;
            // A completed store retires here; the request stays up for the next fetch.
            if (cls_q == CLS_STORE) begin
              state_q <= ST_FETCH;
            end else begin
              state_q   <= ST_WB;
              mem_req_q <= 1'b0;
            end
          end
        end
        ST_WB: begin
          state_q   <= ST_FETCH;
          mem_req_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Enables react to ack/taken within their cycle, so they decode from state here.
  assign ir_we_w_o = (state_q == ST_FETCH) && mem_ack_w_i;
  assign pc_we_w_o = (state_q == ST_WB)
                  || ((state_q == ST_EXEC) && (cls_q == CLS_BRANCH))
                  || ((state_q == ST_MEM) && (cls_q == CLS_STORE) && mem_ack_w_i);
  assign rf_we_w_o = (state_q == ST_WB) && (cls_q != CLS_ILL) && (instr_w_i[11:7] != 5'd0);

  always_comb begin
    pc_sel_w_o = PC_PLUS4;
    if ((state_q == ST_EXEC) && (cls_q == CLS_BRANCH) && branch_taken_w_i)
      pc_sel_w_o = PC_BR;
    else if ((state_q == ST_WB) && (cls_q == CLS_JUMP))
      pc_sel_w_o = PC_ALU;
  end

  assign mem_req_w_o   = mem_req_q;
  assign mem_sel_w_o   = mem_sel_q;
  assign mem_we_w_o    = mem_we_q;
  assign imm_type_w_o  = imm_type_q;
  assign alu_a_sel_w_o = alu_a_q;
  assign alu_b_sel_w_o = alu_b_q;
  assign wb_sel_w_o    = wb_sel_q;
  assign state_w_o     = state_q;
`ifdef CPU_ILLEGAL_TRAP_EN
  assign illegal_w_o   = ill_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed-vector bench for cpu_ctrl_fsm: reset, per-opcode sequencing, waits,
// async reset mid-MEM and illegal handling.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        taken = 1'b0, ack = 1'b0;
  logic        mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_a, alu_b;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_type, state_o;
`ifdef CPU_ILLEGAL_TRAP_EN
  logic        illegal;
  localparam logic [2:0] T = 3'd6;
`endif
  int total = 0, bad = 0;

  localparam logic [2:0] F = 3'd1, D = 3'd2, E = 3'd3, M = 3'd4, W = 3'd5;

  // ctl = {state, req, sel, we, ir_we, pc_we, rf_we, pc_sel}; dp = {imm_type, alu_a, alu_b, wb_sel}
  logic [10:0] ctl, exp_c;
  logic [6:0]  dp, exp_d;
  assign ctl = {state_o, mem_req, mem_sel, mem_we, ir_we, pc_we, rf_we, pc_sel};
  assign dp  = {imm_type, alu_a, alu_b, wb_sel};

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.RESET_DELAY(4)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .instr_w_i        (instr),
    .branch_taken_w_i (taken),
    .mem_ack_w_i      (ack),
    .mem_req_w_o      (mem_req),
    .mem_we_w_o       (mem_we),
    .mem_sel_w_o      (mem_sel),
    .ir_we_w_o        (ir_we),
    .pc_we_w_o        (pc_we),
    .pc_sel_w_o       (pc_sel),
    .imm_type_w_o     (imm_type),
    .alu_a_sel_w_o    (alu_a),
    .alu_b_sel_w_o    (alu_b),
    .rf_we_w_o        (rf_we),
    .wb_sel_w_o       (wb_sel),
`ifdef CPU_ILLEGAL_TRAP_EN
    .illegal_w_o      (illegal),
`endif
    .state_w_o        (state_o)
  );

  task automatic set_in(input logic a, input logic t);
    ack = a; taken = t; #1;
  endtask

  task automatic go(input logic a, input logic t);
    @(negedge clk); set_in(a, t);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ack = 1'b1; taken = 1'b0; instr = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    total++; if ({ctl, dp} !== 18'h0) begin bad++; $display("FAIL reset_all got=%b exp=0", {ctl, dp}); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (ctl !== 11'h0) begin bad++; $display("FAIL rst_wait%0d ctl=%b exp=0", i, ctl); end
      go(i < 3, 1'b0);
    end
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL rst_fetch ctl=%b exp=%b", ctl, exp_c); end
  endtask

  task automatic test_lui;
    instr = 32'h123450B7;
    set_in(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lui_f1 ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lui_f2 ctl=%b exp=%b", ctl, exp_c); end
    go(1'b1, 1'b0);
    exp_c = {F, 6'b100100, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lui_f3 ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    exp_c = {D, 6'b000000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lui_dec ctl=%b exp=%b", ctl, exp_c); end
    go(1'b1, 1'b0);
    exp_c = {E, 6'b000000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lui_exec ctl=%b exp=%b", ctl, exp_c); end
    exp_d = {3'd2, 2'b01, 2'b00};
    total++; if (dp !== exp_d) begin bad++; $display("FAIL lui_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b0, 1'b0);
    exp_c = {W, 6'b000011, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lui_wb ctl=%b exp=%b", ctl, exp_c); end
    total++; if (dp !== exp_d) begin bad++; $display("FAIL lui_wb_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lui_next ctl=%b exp=%b", ctl, exp_c); end
  endtask

  task automatic test_sw;
    instr = 32'h00112223;
    set_in(1'b1, 1'b0);
    exp_c = {F, 6'b100100, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL sw_f ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_c = {E, 6'b000000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL sw_exec ctl=%b exp=%b", ctl, exp_c); end
    exp_d = {3'd3, 2'b01, 2'b00};
    total++; if (dp !== exp_d) begin bad++; $display("FAIL sw_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b0, 1'b0);
    exp_c = {M, 6'b111000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL sw_mem_wait ctl=%b exp=%b", ctl, exp_c); end
    go(1'b1, 1'b0);
    exp_c = {M, 6'b111010, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL sw_mem_ack ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL sw_next ctl=%b exp=%b", ctl, exp_c); end
  endtask

  task automatic test_beq;
    instr = 32'h00000463;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b1);
    exp_c = {E, 6'b000010, 2'b10};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL beq_t_exec ctl=%b exp=%b", ctl, exp_c); end
    exp_d = {3'd4, 2'b00, 2'b00};
    total++; if (dp !== exp_d) begin bad++; $display("FAIL beq_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL beq_t_next ctl=%b exp=%b", ctl, exp_c); end
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_c = {E, 6'b000010, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL beq_nt_exec ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL beq_nt_next ctl=%b exp=%b", ctl, exp_c); end
  endtask

  task automatic test_lw;
    instr = 32'h00012083;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_c = {E, 6'b000000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lw_exec ctl=%b exp=%b", ctl, exp_c); end
    exp_d = {3'd5, 2'b01, 2'b01};
    total++; if (dp !== exp_d) begin bad++; $display("FAIL lw_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b1, 1'b0);
    exp_c = {M, 6'b110000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lw_mem ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    exp_c = {W, 6'b000011, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lw_wb ctl=%b exp=%b", ctl, exp_c); end
    total++; if (dp !== exp_d) begin bad++; $display("FAIL lw_wb_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL lw_next ctl=%b exp=%b", ctl, exp_c); end
  endtask

  task automatic test_jal;
    instr = 32'h008000EF;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_d = {3'd1, 2'b11, 2'b10};
    total++; if (dp !== exp_d) begin bad++; $display("FAIL jal_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b0, 1'b0);
    exp_c = {W, 6'b000011, 2'b01};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL jal_wb ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL jal_next ctl=%b exp=%b", ctl, exp_c); end
  endtask

  task automatic test_rd0;
    instr = 32'h00000013;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_d = {3'd5, 2'b01, 2'b00};
    total++; if (dp !== exp_d) begin bad++; $display("FAIL rd0_dp dp=%b exp=%b", dp, exp_d); end
    go(1'b0, 1'b0);
    exp_c = {W, 6'b000010, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL rd0_wb ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_mem;
    instr = 32'h00012083;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_c = {M, 6'b110000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL mid_mem_wait ctl=%b exp=%b", ctl, exp_c); end
    rst_n = 1'b0;
    #1;
    total++; if (ctl !== 11'h0) begin bad++; $display("FAIL rst_async ctl=%b exp=0", ctl); end
    #2;
    rst_n = 1'b1;
    repeat (4) go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL rst2_fetch ctl=%b exp=%b", ctl, exp_c); end
  endtask

`ifdef CPU_ILLEGAL_TRAP_EN
  task automatic test_illegal;
    instr = 32'h00000000;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_c = {T, 6'b000000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL trap_enter ctl=%b exp=%b", ctl, exp_c); end
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL trap_flag got=%b exp=1", illegal); end
    for (int i = 0; i < 20; i++) begin
      go(1'b1, 1'b0);
      total++; if ({ctl, illegal} !== {exp_c, 1'b1}) begin bad++; $display("FAIL trap_hold%0d ctl=%b ill=%b exp=%b", i, ctl, illegal, exp_c); end
    end
  endtask
`else
  task automatic test_illegal;
    instr = 32'h000000FF;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_c = {W, 6'b000010, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL nop_ff_wb ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL nop_ff_next ctl=%b exp=%b", ctl, exp_c); end
    instr = 32'h00000000;
    set_in(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    exp_c = {W, 6'b000010, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL nop_00_wb ctl=%b exp=%b", ctl, exp_c); end
    go(1'b0, 1'b0);
    exp_c = {F, 6'b100000, 2'b00};
    total++; if (ctl !== exp_c) begin bad++; $display("FAIL nop_00_next ctl=%b exp=%b", ctl, exp_c); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lui();
    test_sw();
    test_beq();
    test_lw();
    test_jal();
    test_rd0();
    test_reset_mid_mem();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control sequencer for the CPE-CPU core. It fetches each instruction over a req/ack memory port and decodes the opcode. It then steps the datapath through DECODE/EXEC/MEM/WB, driving the immediate-generator type select, ALU operand muxes, PC update, memory and register-file write enables. It sits between the instruction register, `imm_gen`, ALU, register file and the unified memory port.

## Interface
- `RESET_DELAY`, default 4: cycles spent in RST_WAIT after reset release before the first fetch (≥1).
- `clk_i`  in  1  core clock; all state changes on rising edge.
- `rst_n_i`  in  1  reset is asynchronous and active-low.
- `instr_w_i`  in  32  instruction register contents (valid from DECODE onward).
- `branch_taken_w_i`  in  1  ALU compare result, valid in EXEC.
- `mem_ack_w_i`  in  1  memory completion; sampled only while `mem_req_w_o`=1.
- `mem_req_w_o`  out  1  memory request, held until ack.
- `mem_we_w_o`  out  1  store request.
- `mem_sel_w_o`  out  1  address source: 0 = PC (fetch), 1 = ALU result (data).
- `ir_we_w_o`  out  1  load instruction register.
- `pc_we_w_o`  out  1  update PC.
- `pc_sel_w_o`  out  2  next-PC source: 00 = PC+4, 01 = ALU result (JAL/JALR), 10 = PC+imm (branch).
- `imm_type_w_o`  out  3  to `imm_gen`: 0 none, 1 J, 2 U, 3 S, 4 B, 5 I.
- `alu_a_sel_w_o`  out  1  0 = rs1, 1 = PC.
- `alu_b_sel_w_o`  out  1  0 = rs2, 1 = immediate.
- `rf_we_w_o`  out  1  register-file write, suppressed when rd (instr[11:7]) = 0.
- `wb_sel_w_o`  out  2  00 = ALU, 01 = memory data, 10 = PC+4.
- `illegal_w_o`  out  1  sticky illegal-instruction flag. Only present with `CPU_ILLEGAL_TRAP_EN`.
- `state_w_o`  out  3  current state encoding, for debug.

## Operation
- States: RST_WAIT, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **RST_WAIT**: a counter runs `RESET_DELAY` cycles, then the FSM moves to FETCH.
- **FETCH**: `mem_req`=1, `mem_sel`=0.
  - Holds until ack.
  - On the ack cycle, `ir_we`=1 and the FSM moves to DECODE.
- **DECODE**: opcode decoded; control outputs are registered and held until the instruction completes.
  - Opcode → `imm_type`: LUI/AUIPC → U; JAL → J; JALR/LOAD/OP-IMM → I; STORE → S; BRANCH → B; OP → 0.
  - `alu_a_sel`=1 for AUIPC and JAL.
  - `alu_b_sel`=1 for every opcode except OP and BRANCH.
- **EXEC**, next state by opcode:
  - BRANCH: `pc_we`=1; `pc_sel`=10 if taken, 00 otherwise; go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- **MEM**: `mem_req`=1, `mem_sel`=1, `mem_we`=1 for STORE. On ack:
  - STORE: `pc_we`=1, `pc_sel`=00, go to FETCH.
  - LOAD: go to WB.
- **WB**: `rf_we` and `pc_we` pulse together, then the FSM moves to FETCH.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - `pc_sel`: 01 for JAL/JALR, 00 otherwise.
- Enable pulses (`ir_we`, `pc_we`, `rf_we`) are exactly one cycle wide.

## Timing
- Reset value of every output is 0; `state_w_o` = RST_WAIT.
- Asserting `rst_n_i` drops `mem_req_w_o` immediately with no clock needed, including mid-FETCH or mid-MEM wait.
- Latency with zero-wait ack (ack in first request cycle):
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each ack wait cycle adds one cycle to the instruction.
- `mem_req` deasserts the cycle after ack.
- An ack with no request pending is ignored.
- `imm_type` is stable from the cycle after DECODE entry until the next FETCH.

## Configuration
- `CPU_ILLEGAL_TRAP_EN` defined:
  - Illegal instructions are an unknown opcode or instr[1:0]≠11.
  - DECODE → TRAP on an illegal instruction; `illegal_w_o`=1.
  - TRAP has no exit: no further requests or enables until reset.
- Undefined:
  - Illegal instructions execute as NOP: DECODE → WB with `rf_we`=0, `pc_we`=1, `pc_sel`=00.
  - `illegal_w_o` port and TRAP state are absent.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode localparams;
  - imm type codes (J=1, U=2, S=3, B=4, I=5), also used by `imm_gen` and its bench;
  - state encoding;
  - `pc_sel` and `wb_sel` codes.
- One combinational sub-module, `ctrl_decode`, maps instr[6:0] to `imm_type`, operand selects, instruction class and the illegal flag. The FSM registers its outputs in DECODE.

## Test plan
- **Reset**: `RESET_DELAY`=4, release reset → all outputs 0 for 4 cycles, then `mem_req`=1. Reassert reset during a MEM wait → `mem_req` falls asynchronously.
- **LUI**: 0x123450B7, ack after 2 wait cycles → `mem_req` held 3 cycles; `ir_we` one pulse; `imm_type`=2; WB pulses `rf_we`+`pc_we` with `pc_sel`=00, `wb_sel`=00.
- **SW**: 0x00112223 → `imm_type`=3; MEM with `mem_we`=1, `mem_sel`=1; `pc_we` on ack; `rf_we` never asserted.
- **BEQ**: 0x00000463 with `branch_taken`=1 → EXEC `pc_we`=1, `pc_sel`=10, total 3 cycles. With `branch_taken`=0 → `pc_sel`=00.
- **LW / JAL**: LW 0x00012083 → FETCH, DECODE, EXEC, MEM, WB with `wb_sel`=01. JAL 0x008000EF → `imm_type`=1, `pc_sel`=01, `wb_sel`=10.
- **Illegal**: 0x00000000 with macro → TRAP, `illegal`=1, no `mem_req` for 20 cycles. Without macro → NOP, `pc_we` in WB, `rf_we`=0.
